// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory responder.
// The program counter uses the same code-window constants.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] CODE_BASE_ADDR     = 32'h0100_0000;
  localparam int unsigned CODE_DEPTH_WORDS   = 1024;
  localparam logic [31:0] CODE_LAST_ADDR     = CODE_BASE_ADDR + 32'(4 * (CODE_DEPTH_WORDS - 1));
  localparam logic [31:0] FAULT_WORD_DEFAULT = 32'hDEAD_BEEF;

  // Word offset of a byte address from the window base, full 32-bit unsigned math.
  function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

  // A fetch faults when misaligned or outside [base, last], compared on the full address.
  function automatic logic addr_faults(input logic [31:0] addr, input logic [31:0] base,
                                       input logic [31:0] last);
    return (addr[1:0] != 2'b00) | (addr < base) | (addr > last);
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-write, single-synchronous-read instruction RAM.
// A read and a write to the same word in one cycle return the old contents.
module imem_ram
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = CODE_DEPTH_WORDS,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data_q;
  logic [31:0] rd_data_d;

  // Read port: capture the addressed word only when a read is issued.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_idx];
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Read data register, cleared so the response word reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts word fetches, checks them against the
// code window, and answers after a fixed wait-state latency with data or a fault.
module imem_responder
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = CODE_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = CODE_DEPTH_WORDS,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] FAULT_WORD  = FAULT_WORD_DEFAULT,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_instr,
  output logic [31:0]      rsp_addr,
  output logic             rsp_fault,
  input  logic             ld_en,
  input  logic [IDX_W-1:0] ld_addr,
  input  logic [31:0]      ld_data,
  output logic             busy
);

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH_WORDS - 1));
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             fault_q, fault_d;
  logic             rd_en;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_data;

  // Next-state logic: accept in IDLE, count down in WAIT, hand off in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    fault_d = fault_q;
    rd_en   = 1'b0;
    rd_idx  = IDX_W'(word_offset(addr_q, BASE_ADDR));
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          fault_d = addr_faults(req_addr, BASE_ADDR, LAST_ADDR);
          cnt_d   = WAIT_INIT;
          if (WAIT_STATES == 0) begin
            rd_en   = !fault_d;
            rd_idx  = IDX_W'(word_offset(req_addr, BASE_ADDR));
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rd_en   = !fault_q;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and latched request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      fault_q <= fault_d;
    end
  end

  imem_ram #(
    .DEPTH(DEPTH_WORDS)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (ld_en),
    .wr_idx (ld_addr),
    .wr_data(ld_data),
    .rd_en  (rd_en),
    .rd_idx (rd_idx),
    .rd_data(rd_data)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_addr  = addr_q;
  assign rsp_fault = fault_q;
  assign rsp_instr = fault_q ? FAULT_WORD : rd_data;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: table vectors, directed corner
// sequences and randomized fetches against a word-array reference model.
module tb_imem_responder;

  localparam int          WS    = 2;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam logic [31:0] FWORD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid0;
  logic [31:0] req_addr;
  logic        rsp_ready, rsp_ready0;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
  logic        req_ready, rsp_valid, rsp_fault, busy;
  logic [31:0] rsp_instr, rsp_addr;
  logic        req_ready0, rsp_valid0, rsp_fault0, busy0;
  logic [31:0] rsp_instr0, rsp_addr0;

  int testsRun    = 0;
  int testsFailed = 0;
  logic [31:0] modelMem [DEPTH];

  typedef struct {
    logic [31:0] addr;
    int          hold;
    logic        expFault;
    logic [31:0] expInstr;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  imem_responder #(.WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_addr(rsp_addr),
    .rsp_fault(rsp_fault), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy)
  );

  imem_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_instr(rsp_instr0), .rsp_addr(rsp_addr0),
    .rsp_fault(rsp_fault0), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy0)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic refFault(input logic [31:0] addr);
    longint unsigned a;
    a = addr;
    return (a % 4 != 0) || (a < longint'(BASE)) || (a >= longint'(BASE) + 4 * DEPTH);
  endfunction

  function automatic int refIdx(input logic [31:0] addr);
    longint unsigned a;
    a = addr;
    return int'((a - longint'(BASE)) / 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input int idx, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = 10'(idx);
    ld_data = data;
    modelMem[idx] = data;
    tick();
    ld_en = 1'b0;
  endtask

  // One full fetch: request, wait-state cycles with optional loads, response hold, release.
  task automatic applyStimulus(input string name, input logic [31:0] addr, input int hold,
                               input bit useTable, input logic tblFault, input logic [31:0] tblInstr,
                               input bit collide, input logic [31:0] colData, input bit randLoads);
    logic        expFault;
    logic [31:0] expInstr;
    int          idx;
    expFault = useTable ? tblFault : refFault(addr);
    idx      = expFault ? 0 : refIdx(addr);
    expInstr = 32'h0;
    checkOutput($sformatf("%s.req_ready_idle", name), 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    rsp_ready = 1'b0;
    for (int k = 0; k <= WS; k++) begin
      if (k == WS) begin
        expInstr = expFault ? FWORD : modelMem[idx];
      end
      ld_en = 1'b0;
      if (collide && k == WS && !expFault) begin
        ld_en   = 1'b1;
        ld_addr = 10'(idx);
        ld_data = colData;
      end else if (randLoads && $urandom_range(2) == 0) begin
        ld_en   = 1'b1;
        ld_addr = ($urandom_range(1) == 0 && !expFault) ? 10'(idx) : 10'($urandom_range(DEPTH - 1));
        ld_data = $urandom;
      end
      if (ld_en) modelMem[ld_addr] = ld_data;
      tick();
      req_valid = 1'b0;
      ld_en     = 1'b0;
      checkOutput($sformatf("%s.rsp_valid_k%0d", name, k), 32'(rsp_valid), (k == WS) ? 32'd1 : 32'd0);
    end
    if (useTable) expInstr = tblInstr;
    checkOutput($sformatf("%s.rsp_instr", name), rsp_instr, expInstr);
    checkOutput($sformatf("%s.rsp_addr", name), rsp_addr, addr);
    checkOutput($sformatf("%s.rsp_fault", name), 32'(rsp_fault), 32'(expFault));
    checkOutput($sformatf("%s.busy", name), 32'(busy), 32'd1);
    checkOutput($sformatf("%s.req_ready_resp", name), 32'(req_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      if (randLoads && $urandom_range(1) == 0) begin
        ld_en   = 1'b1;
        ld_addr = 10'($urandom_range(DEPTH - 1));
        ld_data = $urandom;
        modelMem[ld_addr] = ld_data;
      end
      tick();
      ld_en = 1'b0;
      checkOutput($sformatf("%s.hold%0d_valid", name, h), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("%s.hold%0d_instr", name, h), rsp_instr, expInstr);
      checkOutput($sformatf("%s.hold%0d_addr", name, h), rsp_addr, addr);
      checkOutput($sformatf("%s.hold%0d_ready", name, h), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput($sformatf("%s.released_valid", name), 32'(rsp_valid), 32'd0);
    checkOutput($sformatf("%s.released_busy", name), 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] raddr;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_valid0 = 1'b0;
    req_addr   = '0;
    rsp_ready  = 1'b0;
    rsp_ready0 = 1'b1;
    ld_en      = 1'b0;
    ld_addr    = '0;
    ld_data    = '0;
    tick();
    tick();
    rst = 1'b0;

    checkOutput("reset.req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset.rsp_instr", rsp_instr, 32'd0);
    checkOutput("reset.rsp_addr", rsp_addr, 32'd0);
    checkOutput("reset.rsp_fault", 32'(rsp_fault), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);

    for (int i = 0; i < DEPTH; i++) loadWord(i, $urandom);
    loadWord(0, 32'h0050_0093);
    loadWord(1023, 32'h1234_5678);
    loadWord(4, 32'hA5A5_0004);

    vecs[0] = '{addr: 32'h0100_0000, hold: 0, expFault: 1'b0, expInstr: 32'h0050_0093};
    vecs[1] = '{addr: 32'h0100_0002, hold: 0, expFault: 1'b1, expInstr: FWORD};
    vecs[2] = '{addr: 32'h0100_1000, hold: 0, expFault: 1'b1, expInstr: FWORD};
    vecs[3] = '{addr: 32'h00FF_FFFC, hold: 0, expFault: 1'b1, expInstr: FWORD};
    vecs[4] = '{addr: 32'h0100_0FFC, hold: 5, expFault: 1'b0, expInstr: 32'h1234_5678};
    for (int v = 0; v < 5; v++) begin
      applyStimulus($sformatf("vec%0d", v), vecs[v].addr, vecs[v].hold, 1'b1,
                    vecs[v].expFault, vecs[v].expInstr, 1'b0, 32'h0, 1'b0);
    end
    applyStimulus("after_hold", 32'h0100_0000, 0, 1'b1, 1'b0, 32'h0050_0093, 1'b0, 32'h0, 1'b0);

    applyStimulus("collide_old", 32'h0100_0010, 0, 1'b1, 1'b0, 32'hA5A5_0004, 1'b1, 32'h1111_0004, 1'b0);
    applyStimulus("collide_new", 32'h0100_0010, 0, 1'b1, 1'b0, 32'h1111_0004, 1'b0, 32'h0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(9))
        0:       raddr = BASE + 32'($urandom_range(DEPTH - 1) * 4) + 32'($urandom_range(3, 1));
        1:       raddr = BASE - 32'($urandom_range(4, 1) * 4);
        2:       raddr = BASE + 32'(DEPTH * 4) + 32'($urandom_range(3) * 4);
        default: raddr = BASE + 32'($urandom_range(DEPTH - 1) * 4);
      endcase
      applyStimulus($sformatf("rand%0d", r), raddr, int'($urandom_range(3)), 1'b0, 1'b0, 32'h0,
                    1'b0, 32'h0, 1'b1);
    end

    req_valid = 1'b1;
    req_addr  = 32'h0100_0000;
    tick();
    req_valid = 1'b0;
    checkOutput("rst_wait.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_wait.req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_wait.busy", 32'(busy), 32'd0);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("rst_wait.no_rsp%0d", c), 32'(rsp_valid), 32'd0);
      tick();
    end

    req_valid = 1'b1;
    req_addr  = 32'h0100_0004;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < WS; c++) tick();
    checkOutput("rst_resp.valid_before", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    rsp_ready = 1'b0;
    checkOutput("rst_resp.valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_resp.req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp.rsp_addr", rsp_addr, 32'd0);

    req_addr   = 32'h0100_0000;
    req_valid0 = 1'b1;
    checkOutput("ws0.valid_before", 32'(rsp_valid0), 32'd0);
    tick();
    req_valid0 = 1'b0;
    checkOutput("ws0.valid_t1", 32'(rsp_valid0), 32'd1);
    checkOutput("ws0.instr", rsp_instr0, 32'h0050_0093);
    checkOutput("ws0.fault", 32'(rsp_fault0), 32'd0);
    tick();
    checkOutput("ws0.released", 32'(rsp_valid0), 32'd0);
    req_addr   = 32'h0100_0001;
    req_valid0 = 1'b1;
    tick();
    req_valid0 = 1'b0;
    checkOutput("ws0.fault_valid", 32'(rsp_valid0), 32'd1);
    checkOutput("ws0.fault_instr", rsp_instr0, FWORD);
    checkOutput("ws0.fault_flag", 32'(rsp_fault0), 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
